// File: rtl/lt200_bus_pkg.sv
// lt200_bus_pkg: shared FSM state encoding and completion error codes for the lt200 bus fabric.
package lt200_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_SLAVE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
endpackage

// File: rtl/lt200_bus_watchdog.sv
// lt200_bus_watchdog: counts cycles while enabled; expired flags the LIMIT-th counted cycle.
module lt200_bus_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int W = $clog2(LIMIT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (count_en) cnt <= cnt + 1'b1;
  end
  assign expired = count_en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/lt200_bus_fabric.sv
// lt200_bus_fabric: single-master to NUM_SLAVES address-decoded bus fabric with error reporting.
// Optional WAIT watchdog enabled by defining LT200_BUS_TIMEOUT_EN.
module lt200_bus_fabric
  import lt200_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic [DATA_WIDTH/8-1:0]          be,
  output logic                             ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             bus_err,
  output logic [1:0]                       err_code,
  output logic                             irq,
  output logic [NUM_SLAVES-1:0]            s_enable,
  output logic                             s_wr_en,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_i_data,
  output logic [DATA_WIDTH/8-1:0]          s_be,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_o_data,
  input  logic [NUM_SLAVES-1:0]            s_irq,
  input  logic [NUM_SLAVES-1:0]            s_bus_err
);
  state_t state, next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic wr_q;
  logic [DATA_WIDTH-1:0] data_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [1:0] err_q;
  logic [SEL_BITS-1:0] sel;
  logic valid, slv_rdy, slv_err, timeout;
  logic [NUM_SLAVES-1:0] hit;
  logic [DATA_WIDTH-1:0] slv_data;
  assign sel   = addr_q[ADDR_WIDTH-1 -: SEL_BITS];
  assign valid = 32'(sel) < NUM_SLAVES;
  // Only the selected slave's handshake is ever looked at.
  always_comb begin
    hit = valid ? (NUM_SLAVES'(1) << sel) : '0;
    slv_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      slv_data |= hit[k] ? s_o_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  assign slv_rdy = |(s_ready & hit);
  assign slv_err = |(s_bus_err & hit);
`ifdef LT200_BUS_TIMEOUT_EN
  lt200_bus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != WAIT),
    .count_en (state == WAIT),
    .expired  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = enable ? ISSUE : IDLE;
      ISSUE:   next = !enable ? IDLE : valid ? WAIT : DONE;
      WAIT:    next = !enable ? IDLE : (slv_err || slv_rdy || timeout) ? DONE : WAIT;
      default: next = enable ? DONE : IDLE;
    endcase
    s_enable = (state == ISSUE || state == WAIT) ? hit : '0;
    ready    = state == DONE;
    bus_err  = ready && err_q != ERR_NONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      err_q   <= ERR_NONE;
      rdata_q <= '0;
    end else if (state != IDLE && next == IDLE) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
      be_q   <= '0;
      err_q  <= ERR_NONE;
    end else if (state == IDLE && enable) begin
      addr_q <= addr;
      wr_q   <= wr_en;
      data_q <= i_data;
      be_q   <= be;
    end else if (state == ISSUE && enable && !valid) begin
      err_q   <= ERR_DECODE;
      rdata_q <= '0;
    end else if (state == WAIT && enable && (slv_err || slv_rdy || timeout)) begin
      err_q   <= slv_err ? ERR_SLAVE : slv_rdy ? ERR_NONE : ERR_TIMEOUT;
      rdata_q <= (!slv_err && slv_rdy) ? slv_data : '0;
    end
  end
  assign err_code = err_q;
  assign o_data   = rdata_q;
  assign irq      = |s_irq;
  assign s_wr_en  = wr_q;
  assign s_addr   = {{SEL_BITS{1'b0}}, addr_q[ADDR_WIDTH-SEL_BITS-1:0]};
  assign s_i_data = data_q;
  assign s_be     = be_q;
endmodule

// File: tb/tb_lt200_bus_fabric.sv
// tb_lt200_bus_fabric: directed self-checking bench for lt200_bus_fabric (default 4 slaves, 32-bit).
module tb_lt200_bus_fabric;
  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, i_data = '0;
  logic [3:0] be = '0;
  logic ready, bus_err, irq, s_wr_en;
  logic [31:0] o_data, s_addr, s_i_data;
  logic [1:0] err_code;
  logic [3:0] s_enable, s_be;
  logic [3:0] s_ready = '0, s_irq = '0, s_bus_err = '0;
  logic [127:0] s_o_data = '0;
  int checks = 0, errors = 0;
  bit seen;

  lt200_bus_fabric #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .addr(addr),
    .i_data(i_data), .be(be), .ready(ready), .o_data(o_data), .bus_err(bus_err),
    .err_code(err_code), .irq(irq), .s_enable(s_enable), .s_wr_en(s_wr_en),
    .s_addr(s_addr), .s_i_data(s_i_data), .s_be(s_be), .s_ready(s_ready),
    .s_o_data(s_o_data), .s_irq(s_irq), .s_bus_err(s_bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    s_o_data[0*32 +: 32] = 32'h0000_0A0A;
    s_o_data[1*32 +: 32] = 32'h1111_1111;
    s_o_data[2*32 +: 32] = 32'hDEAD_BEEF;
    s_o_data[3*32 +: 32] = 32'h3333_3333;
    step(); step();
    check("rst_ready", ready, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_o_data", o_data, 0);
    check("rst_s_enable", s_enable, 0);
    check("rst_s_addr", s_addr, 0);
    rst_n = 1'b1;
    step();
    // read slave 2, ready on the third WAIT cycle
    enable = 1'b1; addr = 32'h2000_0010; be = 4'hF;
    step();
    check("rd_s_enable_issue", s_enable, 4'b0100);
    check("rd_s_addr", s_addr, 32'h0000_0010);
    check("rd_ready_issue", ready, 0);
    step(); step();
    check("rd_s_enable_wait", s_enable, 4'b0100);
    step();
    check("rd_ready_wait", ready, 0);
    s_ready = 4'b0100;
    step();
    s_ready = '0;
    check("rd_ready", ready, 1);
    check("rd_o_data", o_data, 32'hDEAD_BEEF);
    check("rd_bus_err", bus_err, 0);
    check("rd_err_code", err_code, 0);
    check("rd_s_enable_done", s_enable, 0);
    step();
    check("rd_hold_ready", ready, 1);
    check("rd_hold_no_restart", s_enable, 0);
    enable = 1'b0;
    step();
    check("rd_idle_ready", ready, 0);
    check("rd_o_data_kept", o_data, 32'hDEAD_BEEF);
    // decode error write
    enable = 1'b1; wr_en = 1'b1; addr = 32'h5000_0000; i_data = 32'hCAFE_F00D; be = 4'b0011;
    step();
    check("dec_s_enable", s_enable, 0);
    check("dec_ready_n1", ready, 0);
    step();
    check("dec_ready_n2", ready, 1);
    check("dec_bus_err", bus_err, 1);
    check("dec_err_code", err_code, 1);
    check("dec_o_data", o_data, 0);
    enable = 1'b0;
    step();
    check("dec_clear_err", err_code, 0);
    check("dec_clear_bus_err", bus_err, 0);
    // write to highest slave
    enable = 1'b1; addr = 32'h3000_0004; i_data = 32'h0BAD_F00D; be = 4'b1100;
    step();
    check("wr_s_enable", s_enable, 4'b1000);
    check("wr_s_wr_en", s_wr_en, 1);
    check("wr_s_i_data", s_i_data, 32'h0BAD_F00D);
    check("wr_s_be", s_be, 4'b1100);
    check("wr_s_addr", s_addr, 32'h0000_0004);
    s_ready = 4'b1000;
    step(); step();
    s_ready = '0;
    check("wr_ready", ready, 1);
    check("wr_err_code", err_code, 0);
    check("wr_o_data", o_data, 32'h3333_3333);
    enable = 1'b0; wr_en = 1'b0;
    step();
    // stray ready from slave 3, then slave 1 error together with its own ready
    enable = 1'b1; addr = 32'h1000_0000;
    step(); step();
    s_ready = 4'b1000;
    step();
    check("stray_ready_ignored", ready, 0);
    check("stray_s_enable", s_enable, 4'b0010);
    s_ready = 4'b0010; s_bus_err = 4'b0010;
    step();
    s_ready = '0; s_bus_err = '0;
    check("serr_ready", ready, 1);
    check("serr_bus_err", bus_err, 1);
    check("serr_err_code", err_code, 2);
    check("serr_o_data", o_data, 0);
    enable = 1'b0;
    step();
    // slave 0 never answers
    enable = 1'b1; addr = 32'h0000_0000;
`ifdef LT200_BUS_TIMEOUT_EN
    for (int i = 0; i < 9; i++) step();
    check("to_ready_before", ready, 0);
    check("to_s_enable_before", s_enable, 4'b0001);
    step();
    check("to_ready", ready, 1);
    check("to_err_code", err_code, 3);
    check("to_s_enable", s_enable, 0);
    enable = 1'b0;
    step();
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      seen |= ready;
    end
    check("noto_ready_seen", seen, 0);
    check("noto_s_enable", s_enable, 4'b0001);
    enable = 1'b0;
    step();
    check("noto_abort_s_enable", s_enable, 0);
`endif
    // abort in WAIT
    enable = 1'b1; addr = 32'h0000_0000;
    step(); step();
    enable = 1'b0;
    step();
    check("abort_s_enable", s_enable, 0);
    check("abort_ready", ready, 0);
    step();
    check("abort_ready_later", ready, 0);
    // reset mid-transaction, then a normal read
    enable = 1'b1; addr = 32'h2000_0000;
    step(); step();
    rst_n = 1'b0;
    step();
    check("mrst_ready", ready, 0);
    check("mrst_s_enable", s_enable, 0);
    check("mrst_o_data", o_data, 0);
    check("mrst_s_addr", s_addr, 0);
    enable = 1'b0; rst_n = 1'b1;
    step();
    s_o_data[2*32 +: 32] = 32'h1234_5678;
    enable = 1'b1; addr = 32'h2000_0000;
    step();
    s_ready = 4'b0100;
    step(); step();
    s_ready = '0;
    check("post_ready", ready, 1);
    check("post_o_data", o_data, 32'h1234_5678);
    check("post_err_code", err_code, 0);
    enable = 1'b0;
    step();
    // irq is a combinational OR
    s_irq = 4'b0010; #1;
    check("irq_on", irq, 1);
    s_irq = 4'b1000; #1;
    check("irq_on_top", irq, 1);
    s_irq = 4'b0000; #1;
    check("irq_off", irq, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
